// File: rtl/cpu_host_loader_if.sv
// Host byte streams, cpu IMEM/DMEM external ports and the cpu run enable.
// The loader takes the master view; the host/memory side takes the slave view.
interface cpu_host_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        enable;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [31:0] rdata_ext;
    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [63:0] wdata_ext_2;
    logic [63:0] rdata_ext_2;

    modport master (
        input  rx_data, rx_valid, tx_ready, rdata_ext, rdata_ext_2,
        output rx_ready, tx_data, tx_valid, enable,
               addr_ext, wen_ext, ren_ext, wdata_ext,
               addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, rdata_ext, rdata_ext_2,
        input  rx_ready, tx_data, tx_valid, enable,
               addr_ext, wen_ext, ren_ext, wdata_ext,
               addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
    );
endinterface

// File: rtl/cpu_host_loader.sv
// Host command decoder driving the cpu IMEM/DMEM external ports and run enable.
// Commands and responses are little-endian byte streams with valid/ready handshakes.
module cpu_host_loader #(
    parameter int         RD_LAT   = 1,
    parameter logic [7:0] ACK_BYTE = 8'hA5,
    parameter logic [7:0] ERR_BYTE = 8'hEE
) (
    input logic               clk,
    input logic               arst_n,
    cpu_host_loader_if.master bus
);
    localparam logic [3:0] WAIT_INIT = 4'(RD_LAT - 1);

    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_DATA, WRITE, RD_REQ, RD_WAIT, SEND, RESP
    } state_t;

    state_t      state;
    logic [7:0]  opcode;
    logic [15:0] addr_buf;
    logic [55:0] data_buf;
    logic [55:0] tx_shift;
    logic [2:0]  byte_cnt;
    logic [3:0]  wait_cnt;
    logic        rx_fire;
    logic        tx_fire;
    logic        op_dmem;
    logic        op_write;
    logic        last_byte;

    assign rx_fire   = bus.rx_valid && bus.rx_ready;
    assign tx_fire   = bus.tx_valid && bus.tx_ready;
    assign op_dmem   = (opcode == 8'h02) || (opcode == 8'h04);
    assign op_write  = (opcode == 8'h01) || (opcode == 8'h02);
    assign last_byte = (byte_cnt == (op_dmem ? 3'd7 : 3'd3));

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state           <= IDLE;
            opcode          <= '0;
            addr_buf        <= '0;
            data_buf        <= '0;
            tx_shift        <= '0;
            byte_cnt        <= '0;
            wait_cnt        <= '0;
            bus.rx_ready    <= 1'b0;
            bus.tx_data     <= '0;
            bus.tx_valid    <= 1'b0;
            bus.enable      <= 1'b0;
            bus.addr_ext    <= '0;
            bus.wen_ext     <= 1'b0;
            bus.ren_ext     <= 1'b0;
            bus.wdata_ext   <= '0;
            bus.addr_ext_2  <= '0;
            bus.wen_ext_2   <= 1'b0;
            bus.ren_ext_2   <= 1'b0;
            bus.wdata_ext_2 <= '0;
        end else begin
            // Strobes are single-cycle: only the transition into WRITE/RD_REQ raises them.
            bus.wen_ext   <= 1'b0;
            bus.wen_ext_2 <= 1'b0;
            bus.ren_ext   <= 1'b0;
            bus.ren_ext_2 <= 1'b0;

            case (state)
                IDLE: begin
                    bus.rx_ready <= 1'b1;
                    if (rx_fire) begin
                        opcode   <= bus.rx_data;
                        byte_cnt <= '0;
                        case (bus.rx_data)
                            8'h01, 8'h02, 8'h03, 8'h04: state <= GET_ADDR;
                            8'h05, 8'h06: begin
                                bus.enable   <= (bus.rx_data == 8'h05);
                                bus.rx_ready <= 1'b0;
                                bus.tx_data  <= ACK_BYTE;
                                bus.tx_valid <= 1'b1;
                                state        <= RESP;
                            end
                            default: begin
                                bus.rx_ready <= 1'b0;
                                bus.tx_data  <= ERR_BYTE;
                                bus.tx_valid <= 1'b1;
                                state        <= RESP;
                            end
                        endcase
                    end
                end

                GET_ADDR: begin
                    if (rx_fire) begin
                        if (!byte_cnt[0]) begin
                            addr_buf[7:0] <= bus.rx_data;
                            byte_cnt      <= 3'd1;
                        end else begin
                            addr_buf[15:8] <= bus.rx_data;
                            byte_cnt       <= '0;
                            if (op_write) begin
                                state <= GET_DATA;
                            end else begin
                                bus.rx_ready <= 1'b0;
                                state        <= RD_REQ;
                                if (op_dmem) begin
                                    bus.addr_ext_2 <= {48'b0, bus.rx_data, addr_buf[7:0]};
                                    bus.ren_ext_2  <= 1'b1;
                                end else begin
                                    bus.addr_ext <= {48'b0, bus.rx_data, addr_buf[7:0]};
                                    bus.ren_ext  <= 1'b1;
                                end
                            end
                        end
                    end
                end

                // Data bytes shift in from the top so the final byte completes the word in place.
                GET_DATA: begin
                    if (rx_fire) begin
                        if (last_byte) begin
                            bus.rx_ready <= 1'b0;
                            byte_cnt     <= '0;
                            state        <= WRITE;
                            if (op_dmem) begin
                                bus.addr_ext_2  <= {48'b0, addr_buf};
                                bus.wdata_ext_2 <= {bus.rx_data, data_buf};
                                bus.wen_ext_2   <= 1'b1;
                            end else begin
                                bus.addr_ext  <= {48'b0, addr_buf};
                                bus.wdata_ext <= {bus.rx_data, data_buf[55:32]};
                                bus.wen_ext   <= 1'b1;
                            end
                        end else begin
                            data_buf <= {bus.rx_data, data_buf[55:8]};
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end
                end

                WRITE: begin
                    bus.tx_data  <= ACK_BYTE;
                    bus.tx_valid <= 1'b1;
                    state        <= RESP;
                end

                RD_REQ: begin
                    wait_cnt <= WAIT_INIT;
                    state    <= RD_WAIT;
                end

                RD_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        if (op_dmem) begin
                            bus.tx_data <= bus.rdata_ext_2[7:0];
                            tx_shift    <= bus.rdata_ext_2[63:8];
                        end else begin
                            bus.tx_data <= bus.rdata_ext[7:0];
                            tx_shift    <= {32'b0, bus.rdata_ext[31:8]};
                        end
                        bus.tx_valid <= 1'b1;
                        byte_cnt     <= '0;
                        state        <= SEND;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                SEND: begin
                    if (tx_fire) begin
                        if (last_byte) begin
                            bus.tx_valid <= 1'b0;
                            bus.rx_ready <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            bus.tx_data <= tx_shift[7:0];
                            tx_shift    <= {8'h00, tx_shift[55:8]};
                            byte_cnt    <= byte_cnt + 3'd1;
                        end
                    end
                end

                RESP: begin
                    if (tx_fire) begin
                        bus.tx_valid <= 1'b0;
                        bus.rx_ready <= 1'b1;
                        state        <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_host_loader.sv
// Self-checking bench for cpu_host_loader: directed scenarios followed by random
// commands, scored against a byte-level protocol model and simple SRAM models.
module tb_cpu_host_loader;
    logic clk    = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    cpu_host_loader_if bus();

    cpu_host_loader #(.RD_LAT(1), .ACK_BYTE(8'hA5), .ERR_BYTE(8'hEE)) dut (
        .clk   (clk),
        .arst_n(arst_n),
        .bus   (bus.master)
    );

    int compared   = 0;
    int mismatched = 0;

    // Synchronous SRAMs behind the external ports (one-cycle read latency)
    logic [31:0] imem_sram [0:65535];
    logic [63:0] dmem_sram [0:65535];

    always @(posedge clk) begin
        if (bus.wen_ext)   imem_sram[bus.addr_ext[15:0]]   <= bus.wdata_ext;
        if (bus.ren_ext)   bus.rdata_ext                   <= imem_sram[bus.addr_ext[15:0]];
        if (bus.wen_ext_2) dmem_sram[bus.addr_ext_2[15:0]] <= bus.wdata_ext_2;
        if (bus.ren_ext_2) bus.rdata_ext_2                 <= dmem_sram[bus.addr_ext_2[15:0]];
    end

    // Bus monitor: access counts, captured addresses/data, stream timing, received bytes
    int          cyc = 0, last_rx_cyc = 0, txv_rise_cyc = 0, long_pulse = 0;
    int          wen_cnt = 0, wen2_cnt = 0, ren_cnt = 0, ren2_cnt = 0;
    logic [63:0] wen_addr = '0, wen_data = '0, wen2_addr = '0, wen2_data = '0;
    logic [63:0] ren_addr = '0, ren2_addr = '0;
    logic [3:0]  pulses;
    logic [3:0]  pulses_d = '0;
    logic        txv_d = 1'b0;
    logic [7:0]  got_q [$];

    assign pulses = {bus.wen_ext, bus.wen_ext_2, bus.ren_ext, bus.ren_ext_2};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.wen_ext)   begin wen_cnt  <= wen_cnt + 1;  wen_addr  <= bus.addr_ext;   wen_data  <= {32'b0, bus.wdata_ext}; end
        if (bus.wen_ext_2) begin wen2_cnt <= wen2_cnt + 1; wen2_addr <= bus.addr_ext_2; wen2_data <= bus.wdata_ext_2; end
        if (bus.ren_ext)   begin ren_cnt  <= ren_cnt + 1;  ren_addr  <= bus.addr_ext;   end
        if (bus.ren_ext_2) begin ren2_cnt <= ren2_cnt + 1; ren2_addr <= bus.addr_ext_2; end
        if ((pulses & pulses_d) != 4'b0) long_pulse <= long_pulse + 1;
        pulses_d <= pulses;
        if (bus.rx_valid && bus.rx_ready) last_rx_cyc <= cyc;
        if (bus.tx_valid && bus.tx_ready) got_q.push_back(bus.tx_data);
    end

    always @(negedge clk) begin
        if (bus.tx_valid && !txv_d) txv_rise_cyc <= cyc;
        txv_d <= bus.tx_valid;
    end

    // Reference model state: memory contents, run flag, expected access totals
    logic [31:0] ref_imem [int];
    logic [63:0] ref_dmem [int];
    logic        ref_enable = 1'b0;
    int          exp_wen = 0, exp_wen2 = 0, exp_ren = 0, exp_ren2 = 0;
    int          exp_lat = 0, last_kind = 0;
    logic [63:0] exp_acc_addr = '0, exp_wr_data = '0;
    logic [7:0]  cmd_q [$];
    logic [7:0]  exp_q [$];
    int          imem_addrs [$];
    int          dmem_addrs [$];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sends cmd_q byte by byte, optionally with random idle gaps; returns at a negedge
    task automatic applyStimulus(input int max_gap);
        foreach (cmd_q[i]) begin
            int n;
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
            bus.rx_data  = cmd_q[i];
            bus.rx_valid = 1'b1;
            n = 0;
            while (bus.rx_ready !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) checkOutput("rx_accept_timeout", 64'(n), 64'd0);
            @(negedge clk);
            bus.rx_valid = 1'b0;
        end
        cmd_q.delete();
    endtask

    task automatic buildWrite(input bit dmem, input logic [15:0] a, input logic [63:0] d);
        cmd_q.push_back(dmem ? 8'h02 : 8'h01);
        cmd_q.push_back(a[7:0]);
        cmd_q.push_back(a[15:8]);
        for (int k = 0; k < (dmem ? 8 : 4); k++) cmd_q.push_back(d[8*k +: 8]);
        if (dmem) begin
            ref_dmem[int'(a)] = d;
            exp_wen2++;
            exp_wr_data = d;
            dmem_addrs.push_back(int'(a));
        end else begin
            ref_imem[int'(a)] = d[31:0];
            exp_wen++;
            exp_wr_data = {32'b0, d[31:0]};
            imem_addrs.push_back(int'(a));
        end
        exp_acc_addr = {48'b0, a};
        last_kind    = dmem ? 2 : 1;
        exp_lat      = 2;
        exp_q.push_back(8'hA5);
    endtask

    task automatic buildRead(input bit dmem, input logic [15:0] a);
        logic [63:0] v;
        cmd_q.push_back(dmem ? 8'h04 : 8'h03);
        cmd_q.push_back(a[7:0]);
        cmd_q.push_back(a[15:8]);
        if (dmem) begin
            v = ref_dmem.exists(int'(a)) ? ref_dmem[int'(a)] : 64'd0;
            exp_ren2++;
        end else begin
            v = ref_imem.exists(int'(a)) ? {32'b0, ref_imem[int'(a)]} : 64'd0;
            exp_ren++;
        end
        for (int k = 0; k < (dmem ? 8 : 4); k++) exp_q.push_back(v[8*k +: 8]);
        exp_acc_addr = {48'b0, a};
        last_kind    = dmem ? 4 : 3;
        exp_lat      = 3;
    endtask

    task automatic buildSimple(input logic [7:0] op);
        cmd_q.push_back(op);
        if (op == 8'h05 || op == 8'h06) begin
            ref_enable = (op == 8'h05);
            exp_q.push_back(8'hA5);
        end else begin
            exp_q.push_back(8'hEE);
        end
        last_kind = 0;
        exp_lat   = 1;
    endtask

    task automatic checkResponse(input string tag);
        int n = 0;
        logic [63:0] v;
        while (got_q.size() < exp_q.size() && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checkOutput($sformatf("%s_len", tag), 64'(got_q.size()), 64'(exp_q.size()));
        foreach (exp_q[i]) begin
            v = 'x;
            if (i < got_q.size()) v = 64'(got_q[i]);
            checkOutput($sformatf("%s_byte%0d", tag, i), v, 64'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic finishCmd(input string tag);
        checkResponse(tag);
        checkOutput($sformatf("%s_counts", tag),
                    {16'(wen_cnt), 16'(wen2_cnt), 16'(ren_cnt), 16'(ren2_cnt)},
                    {16'(exp_wen), 16'(exp_wen2), 16'(exp_ren), 16'(exp_ren2)});
        checkOutput($sformatf("%s_enable", tag), 64'(bus.enable), 64'(ref_enable));
        checkOutput($sformatf("%s_long_pulse", tag), 64'(long_pulse), 64'd0);
        checkOutput($sformatf("%s_latency", tag), 64'(txv_rise_cyc - last_rx_cyc), 64'(exp_lat));
        case (last_kind)
            1: begin
                checkOutput($sformatf("%s_waddr", tag), wen_addr, exp_acc_addr);
                checkOutput($sformatf("%s_wdata", tag), wen_data, exp_wr_data);
            end
            2: begin
                checkOutput($sformatf("%s_waddr2", tag), wen2_addr, exp_acc_addr);
                checkOutput($sformatf("%s_wdata2", tag), wen2_data, exp_wr_data);
            end
            3: checkOutput($sformatf("%s_raddr", tag), ren_addr, exp_acc_addr);
            4: checkOutput($sformatf("%s_raddr2", tag), ren2_addr, exp_acc_addr);
            default: ;
        endcase
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] a;
        logic [7:0]  op;
        int          n;

        for (int i = 0; i < 65536; i++) begin
            imem_sram[i] = '0;
            dmem_sram[i] = '0;
        end
        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;

        // Reset values, then rx_ready rises one cycle after release
        repeat (3) @(negedge clk);
        checkOutput("rst_rx_ready", 64'(bus.rx_ready), 64'd0);
        checkOutput("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
        checkOutput("rst_tx_data", 64'(bus.tx_data), 64'd0);
        checkOutput("rst_enable", 64'(bus.enable), 64'd0);
        checkOutput("rst_strobes", 64'(pulses), 64'd0);
        checkOutput("rst_addr_ext", bus.addr_ext, 64'd0);
        checkOutput("rst_addr_ext_2", bus.addr_ext_2, 64'd0);
        checkOutput("rst_wdata_ext", 64'(bus.wdata_ext), 64'd0);
        checkOutput("rst_wdata_ext_2", bus.wdata_ext_2, 64'd0);
        arst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_rx_ready", 64'(bus.rx_ready), 64'd1);
        checkOutput("post_rst_enable", 64'(bus.enable), 64'd0);

        // IMEM write: 01 10 00 13 05 A0 00
        buildWrite(1'b0, 16'h0010, 64'h0000_0000_00A0_0513);
        applyStimulus(0);
        finishCmd("imem_wr");

        // DMEM write then read back with a 5-cycle stall on response byte 3
        buildWrite(1'b1, 16'h0008, 64'h0123_4567_89AB_CDEF);
        applyStimulus(0);
        finishCmd("dmem_wr");

        buildRead(1'b1, 16'h0008);
        applyStimulus(0);
        n = 0;
        while (got_q.size() < 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.tx_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp_tx_data", 64'(bus.tx_data), 64'(exp_q[3]));
            checkOutput("bp_tx_valid", 64'(bus.tx_valid), 64'd1);
            checkOutput("bp_rx_ready", 64'(bus.rx_ready), 64'd0);
            checkOutput("bp_got_count", 64'(got_q.size()), 64'd3);
        end
        bus.tx_ready = 1'b1;
        finishCmd("dmem_rd");

        // Run, IMEM read while running, halt, unknown opcode
        buildSimple(8'h05);
        applyStimulus(0);
        finishCmd("run");
        buildRead(1'b0, 16'h0000);
        applyStimulus(0);
        finishCmd("imem_rd_running");
        buildSimple(8'h06);
        applyStimulus(0);
        finishCmd("halt");
        buildSimple(8'h7F);
        applyStimulus(0);
        finishCmd("bad_op");

        // Partial write aborted by reset: no strobe, no response, outputs cleared
        cmd_q = {8'h01, 8'h20, 8'h00, 8'h11};
        applyStimulus(0);
        arst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort_addr_ext", bus.addr_ext, 64'd0);
        checkOutput("abort_rx_ready", 64'(bus.rx_ready), 64'd0);
        repeat (2) @(negedge clk);
        arst_n     = 1'b1;
        ref_enable = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("abort_wen_count", 64'(wen_cnt), 64'(exp_wen));
        checkOutput("abort_no_tx", 64'(got_q.size()), 64'd0);
        buildSimple(8'h05);
        applyStimulus(0);
        finishCmd("fresh_run");

        // Random command mix with idle gaps between bytes
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 8))
                0, 1: buildWrite(1'b0, 16'($urandom), {$urandom, $urandom});
                2, 3: buildWrite(1'b1, 16'($urandom), {$urandom, $urandom});
                4: begin
                    a = 16'($urandom);
                    if (imem_addrs.size() > 0 && $urandom_range(0, 1) == 1)
                        a = 16'(imem_addrs[$urandom_range(0, imem_addrs.size() - 1)]);
                    buildRead(1'b0, a);
                end
                5: begin
                    a = 16'($urandom);
                    if (dmem_addrs.size() > 0 && $urandom_range(0, 1) == 1)
                        a = 16'(dmem_addrs[$urandom_range(0, dmem_addrs.size() - 1)]);
                    buildRead(1'b1, a);
                end
                6: buildSimple(8'h05);
                7: buildSimple(8'h06);
                default: begin
                    op = 8'($urandom_range(7, 255));
                    buildSimple(op);
                end
            endcase
            applyStimulus(2);
            finishCmd($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/cpu_host_loader.md
Name: cpu_host_loader

Overview:
- Host-side initiator for the cpu external memory ports (addr_ext/wen_ext/ren_ext/wdata_ext/rdata_ext for instruction memory; the *_2 set for data memory) and the cpu enable input.
- Decodes a byte-stream command protocol (valid/ready) from a host link, performs IMEM/DMEM writes and reads, returns responses on a byte stream, and starts/stops execution.
- Sits between the top-level debug/UART link and cpu.

Parameters:
- RD_LAT, 1, cycles from ren_ext/ren_ext_2 assertion to valid rdata_ext/rdata_ext_2 (synchronous SRAM read).
- ACK_BYTE, 8'hA5, response byte after a completed write, run or halt.
- ERR_BYTE, 8'hEE, response byte for an unknown opcode.

Ports:
- clk  in  1  main clock
- arst_n  in  1  reset, asynchronous, active-low
- rx_data  in  8  command byte from host
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts rx_data this cycle
- tx_data  out  8  response byte to host
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  host accepts tx_data
- enable  out  1  cpu execution enable
- addr_ext  out  64  IMEM external byte address
- wen_ext  out  1  IMEM external write enable
- ren_ext  out  1  IMEM external read enable
- wdata_ext  out  32  IMEM write word
- rdata_ext  in  32  IMEM read word
- addr_ext_2  out  64  DMEM external byte address
- wen_ext_2  out  1  DMEM external write enable
- ren_ext_2  out  1  DMEM external read enable
- wdata_ext_2  out  64  DMEM write doubleword
- rdata_ext_2  in  64  DMEM read doubleword

Behaviour:
- Reset: all outputs 0 (enable=0, rx_ready=0, tx_valid=0, all address/data/enables 0). FSM goes to IDLE. Reset asserted mid-command aborts it with no memory access and no response.
- A byte transfers when valid&ready are both high on a rising edge, on both streams.
- Commands (multi-byte fields little-endian):
  - 0x01 write IMEM: A0 A1 D0..D3
  - 0x02 write DMEM: A0 A1 D0..D7
  - 0x03 read IMEM: A0 A1; response is 4 bytes
  - 0x04 read DMEM: A0 A1; response is 8 bytes
  - 0x05 run: set enable=1
  - 0x06 halt: set enable=0
- Address: {48'b0,A1,A0} is the byte address and drives addr_ext or addr_ext_2 directly. Address is not aligned or checked.
- States: IDLE, GET_ADDR (2 bytes), GET_DATA (4 or 8 bytes), WRITE, RD_REQ, RD_WAIT, SEND (4 or 8 bytes), RESP.
  - rx_ready=1 only in IDLE, GET_ADDR and GET_DATA.
- IDLE: the accepted opcode selects the path.
  - 0x01/0x02 -> GET_ADDR -> GET_DATA.
  - 0x03/0x04 -> GET_ADDR -> RD_REQ.
  - 0x05/0x06 update enable on the acceptance edge, then go to RESP with ACK_BYTE.
  - Any other opcode -> RESP with ERR_BYTE.
- WRITE: the selected wen is high for exactly 1 cycle, with addr and wdata stable in the same cycle. Next cycle -> RESP with ACK_BYTE.
- RD_REQ: the selected ren is high for 1 cycle with addr valid.
- RD_WAIT: waits RD_LAT cycles, captures rdata into a shift register, then -> SEND.
- SEND: presents bytes LSB first. tx_valid stays high and tx_data stays stable until tx_ready; no bubble between bytes. After the last byte -> IDLE.
- RESP: same hold rule for a single byte, then -> IDLE.
- Outside WRITE/RD_REQ: wen*/ren* are 0. addr/wdata hold their last values.
- enable changes only on 0x05/0x06. It stays 1 while memory commands execute, because the external ports are independent SRAM ports.
- Byte counters are 3 bits and wrap-free; the count is decided by the opcode.
- No timeouts: a partial command waits indefinitely for its remaining bytes.
- tx_ready held low stalls the FSM. No further rx bytes are accepted until the response completes.
- Write-response latency: ACK tx_valid rises 2 cycles after the last data byte is accepted.
- Read latency: the first tx byte is valid RD_LAT+2 cycles after A1 is accepted.

Test Plan:
- Reset check: hold arst_n=0 -> all outputs 0. Release -> rx_ready=1 next cycle, enable=0.
- IMEM write: send 01 10 00 13 05 A0 00 (back-to-back) -> one-cycle wen_ext with addr_ext=0x10 and wdata_ext=0x00A00513. Then tx byte A5. wen_ext_2 never asserts.
- DMEM write then read: write 02 08 00 EF CD AB 89 67 45 23 01, then send 04 08 00 with the memory model returning the written doubleword -> tx bytes EF CD AB 89 67 45 23 01 in order. ren_ext_2 pulses 1 cycle at addr 0x08.
- Backpressure: during the read response, hold tx_ready=0 for 5 cycles on byte 3 -> tx_data stable, tx_valid=1, rx_ready=0, no byte lost or duplicated.
- Run/halt: send 05 -> enable=1 and A5 returned. Send 03 00 00 while running -> IMEM read completes, enable stays 1. Send 06 -> enable=0 and A5 returned.
- Error/abort: send 7F -> EE returned, then IDLE. Send 01 20 00 11, then pulse arst_n low -> no wen_ext, no tx. A fresh 05 afterwards works normally.
